// File: rtl/perceptron_update_pkg.sv
// Shared fixed-point constants, helpers and enums for the perceptron update block.
// PERCEPTRON_UPDATE_SAT_EN: saturate products and sums instead of wrapping.
package perceptron_update_pkg;

    // Fixed-point format Q16.16
    localparam int                 FRAC_BITS = 16;
    localparam logic signed [31:0] FX_ONE    = 32'sh0001_0000;
    localparam logic signed [31:0] FX_MAX    = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] FX_MIN    = 32'sh8000_0000;

    // Activation used by the forward pass
    typedef enum logic [1:0] {
        IDENTITY,
        HEAVISIDE_STEP,
        RELU,
        SIGMOID
    } act_func;

    // Training sequencer states
    typedef enum logic [2:0] {
        IDLE,
        CALC,
        UPDATE,
        BIAS,
        DONE
    } update_state_t;

    // Bring a wide intermediate back to 32 bits
    function automatic logic signed [31:0] fx_reduce(
        input logic signed [63:0] v
    );
`ifdef PERCEPTRON_UPDATE_SAT_EN
        if (v > 64'(FX_MAX)) begin
            return FX_MAX;
        end else if (v < 64'(FX_MIN)) begin
            return FX_MIN;
        end else begin
            return v[31:0];
        end
`else
        return v[31:0];
`endif
    endfunction

    // Fixed-point add with the same reduction as the multiplier
    function automatic logic signed [31:0] fx_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b
    );
        logic signed [63:0] s;
        s = 64'(a) + 64'(b);
        return fx_reduce(s);
    endfunction

endpackage

// File: rtl/perceptron_update_fx_mul_sat.sv
// Combinational Q16.16 multiply: full product, arithmetic shift, reduce.
// Honours PERCEPTRON_UPDATE_SAT_EN through fx_reduce.
module fx_mul_sat
    import perceptron_update_pkg::*;
(
    input  logic signed [31:0] a_i,
    input  logic signed [31:0] b_i,
    output logic signed [31:0] y_o
);

    logic signed [63:0] prod;
    logic signed [63:0] shifted;

    // Full-width product, then realign the binary point
    always_comb begin
        prod    = 64'(a_i) * 64'(b_i);
        shifted = prod >>> FRAC_BITS;
        y_o     = fx_reduce(shifted);
    end

endmodule

// File: rtl/perceptron_update.sv
// Perceptron training stage: error, derivative, serial weight/bias update.
// Define PERCEPTRON_UPDATE_SAT_EN for saturating arithmetic (default wraps).
module perceptron_update
    import perceptron_update_pkg::*;
#(
    parameter int N_INPUTS = 4,
    parameter int W_INIT   = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  act_func            activation,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [31:0] features [N_INPUTS],
    input  logic signed [31:0] sum,
    input  logic signed [31:0] prediction,
    input  logic signed [31:0] target,
    input  logic signed [31:0] learn_rate,
    output logic signed [31:0] weights [N_INPUTS],
    output logic signed [31:0] bias,
    output logic signed [31:0] err_out,
    output logic               out_valid
);

    localparam int IW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(N_INPUTS - 1);

    update_state_t      state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;

    act_func            act_q;
    logic signed [31:0] feat_q [N_INPUTS];
    logic signed [31:0] sum_q;
    logic signed [31:0] pred_q;
    logic signed [31:0] tgt_q;
    logic signed [31:0] lr_q;
    logic signed [31:0] delta_q;
    logic signed [31:0] w_q [N_INPUTS];
    logic signed [31:0] bias_q;
    logic signed [31:0] err_q;

    logic               accept;
    logic signed [31:0] err_c;
    logic signed [31:0] deriv_c;
    logic signed [31:0] lr_err_c;
    logic signed [31:0] delta_c;
    logic signed [31:0] wstep_c;
    logic signed [31:0] wsum_c;
    logic signed [31:0] bsum_c;

    assign accept = in_ready && in_valid;

    // Error and activation derivative from the latched sample
    always_comb begin
        err_c   = tgt_q - pred_q;
        deriv_c = FX_ONE;
        if (act_q == HEAVISIDE_STEP) begin
            err_c = err_c <<< FRAC_BITS;
        end
        case (act_q)
            RELU:    deriv_c = (sum_q > 0) ? FX_ONE : '0;
            default: deriv_c = FX_ONE;
        endcase
    end

    fx_mul_sat u_mul_lr (
        .a_i (lr_q),
        .b_i (err_c),
        .y_o (lr_err_c)
    );

    fx_mul_sat u_mul_deriv (
        .a_i (lr_err_c),
        .b_i (deriv_c),
        .y_o (delta_c)
    );

    fx_mul_sat u_mul_w (
        .a_i (delta_q),
        .b_i (feat_q[idx_q]),
        .y_o (wstep_c)
    );

    // Accumulator adders for the selected weight and the bias
    always_comb begin
        wsum_c = fx_add(w_q[idx_q], wstep_c);
        bsum_c = fx_add(bias_q, delta_q);
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (delta_c == '0) begin
                    state_d = DONE;
                end else begin
                    state_d = UPDATE;
                    idx_d   = '0;
                end
            end
            UPDATE: begin
                if (idx_q == IDX_LAST) begin
                    state_d = BIAS;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            BIAS: begin
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Capture the sample on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q  <= IDENTITY;
            sum_q  <= '0;
            pred_q <= '0;
            tgt_q  <= '0;
            lr_q   <= '0;
            for (int i = 0; i < N_INPUTS; i++) begin
                feat_q[i] <= '0;
            end
        end else if (accept) begin
            act_q  <= activation;
            sum_q  <= sum;
            pred_q <= prediction;
            tgt_q  <= target;
            lr_q   <= learn_rate;
            for (int i = 0; i < N_INPUTS; i++) begin
                feat_q[i] <= features[i];
            end
        end
    end

    // Latch error and step size during CALC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delta_q <= '0;
            err_q   <= '0;
        end else if (state_q == CALC) begin
            delta_q <= delta_c;
            err_q   <= err_c;
        end
    end

    // Serial weight update and final bias update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                w_q[i] <= W_INIT;
            end
            bias_q <= '0;
        end else if (state_q == UPDATE) begin
            w_q[idx_q] <= wsum_c;
        end else if (state_q == BIAS) begin
            bias_q <= bsum_c;
        end
    end

    assign weights = w_q;
    assign bias    = bias_q;
    assign err_out = err_q;

endmodule

// File: tb/tb_perceptron_update.sv
// Randomized bench for perceptron_update against a behavioural model.
// Follows PERCEPTRON_UPDATE_SAT_EN for the expected arithmetic.
module tb_perceptron_update;
    import perceptron_update_pkg::*;

    localparam int N = 4;

    logic               clk;
    logic               rst_n;
    act_func            act;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] feat [N];
    logic signed [31:0] sum_v;
    logic signed [31:0] pred_v;
    logic signed [31:0] tgt_v;
    logic signed [31:0] lr_v;
    logic signed [31:0] w_o [N];
    logic signed [31:0] bias_o;
    logic signed [31:0] err_o;
    logic               out_valid;

    int n_cmp = 0;
    int n_bad = 0;

    longint mw [N];
    longint mb;
    longint merr;

    perceptron_update #(.N_INPUTS(N), .W_INIT(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .activation (act),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .features   (feat),
        .sum        (sum_v),
        .prediction (pred_v),
        .target     (tgt_v),
        .learn_rate (lr_v),
        .weights    (w_o),
        .bias       (bias_o),
        .err_out    (err_o),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint got,
                            input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference arithmetic: clamp or wrap a mathematical value to 32 bits
    function automatic longint red(input longint v);
`ifdef PERCEPTRON_UPDATE_SAT_EN
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
`else
        int t;
        t = int'(v);
        return longint'(t);
`endif
    endfunction

    function automatic longint fmul(input longint a, input longint b);
        return red((a * b) >>> 16);
    endfunction

    function automatic longint fadd(input longint a, input longint b);
        return red(a + b);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) mw[i] = 0;
        mb   = 0;
        merr = 0;
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < N; i++) begin
            check_eq($sformatf("%s_w%0d", tag, i), longint'(w_o[i]), mw[i]);
        end
        check_eq({tag, "_bias"}, longint'(bias_o), mb);
        check_eq({tag, "_err"}, longint'(err_o), merr);
    endtask

    // Apply one sample; caller is at posedge+1 with the block idle
    task automatic run_sample(input string tag, input bit poke);
        longint e;
        longint d;
        longint deriv;
        int     explat;
        int     lat;
        bit     seen;
        logic signed [31:0] sv_f0;
        logic signed [31:0] sv_lr;

        e = longint'(tgt_v) - longint'(pred_v);
        if (act == HEAVISIDE_STEP) e = e * 65536;
        e = longint'(int'(e));
        deriv = 65536;
        if (act == RELU && sum_v <= 0) deriv = 0;
        d = fmul(fmul(longint'(lr_v), e), deriv);
        merr = e;
        if (d == 0) begin
            explat = 1;
        end else begin
            explat = N + 2;
            for (int i = 0; i < N; i++) begin
                mw[i] = fadd(mw[i], fmul(d, longint'(feat[i])));
            end
            mb = fadd(mb, d);
        end

        check_eq({tag, "_rdy"}, longint'(in_ready), 1);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat   = 0;
        seen  = 1'b0;
        sv_f0 = feat[0];
        sv_lr = lr_v;
        while (!seen && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (poke && lat == 3) begin
                in_valid = 1'b0;
                feat[0]  = sv_f0;
                lr_v     = sv_lr;
            end
            if (out_valid) begin
                seen = 1'b1;
            end else if (lat == 1) begin
                check_eq({tag, "_busy"}, longint'(in_ready), 0);
            end
            if (poke && lat == 2 && !seen) begin
                in_valid = 1'b1;
                feat[0]  = sv_f0 + 32'sd777216;
                lr_v     = sv_lr + 32'sd65536;
            end
        end
        in_valid = 1'b0;
        feat[0]  = sv_f0;
        lr_v     = sv_lr;
        check_eq({tag, "_lat"}, seen ? lat : -1, explat);
        check_state(tag);
        @(posedge clk);
        #1;
        check_eq({tag, "_pulse"}, longint'(out_valid), 0);
        check_eq({tag, "_idle"}, longint'(in_ready), 1);
    endtask

    function automatic logic signed [31:0] rnd_fx(input int span);
        return 32'(signed'($urandom_range(0, 2 * span))) - 32'(span);
    endfunction

    int ovc;
    longint w0_start;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        act      = IDENTITY;
        sum_v    = '0;
        pred_v   = '0;
        tgt_v    = '0;
        lr_v     = '0;
        for (int i = 0; i < N; i++) feat[i] = '0;
        model_reset();
        #22;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_state("rst");
        check_eq("rst_ov", longint'(out_valid), 0);
        check_eq("rst_rdy", longint'(in_ready), 1);

        // Identity full update
        act = IDENTITY;
        lr_v = 32768; tgt_v = 65536; pred_v = 0; sum_v = 0;
        feat[0] = 65536; feat[1] = 131072; feat[2] = 0; feat[3] = -65536;
        run_sample("ident", 1'b0);
        check_eq("ident_w1_abs", longint'(w_o[1]), 65536);
        check_eq("ident_w3_abs", longint'(w_o[3]), -32768);

        // Zero-delta skips
        tgt_v = 65536; pred_v = 65536;
        run_sample("zd_eq", 1'b0);
        act = RELU; sum_v = -5; tgt_v = 65536; pred_v = 0;
        run_sample("zd_relu", 1'b0);

        // Heaviside scaling with a busy poke
        act = HEAVISIDE_STEP; tgt_v = 1; pred_v = 0; lr_v = 65536;
        feat[0] = 65536; feat[1] = 0; feat[2] = 0; feat[3] = 0;
        run_sample("heav", 1'b1);
        check_eq("heav_err_abs", longint'(err_o), 65536);

        // Saturation / wrap
        w0_start = mw[0];
        act = IDENTITY; lr_v = 32'sh7FFF_FFFF; tgt_v = 32'sh4000_0000;
        pred_v = 0;
        feat[0] = 131072; feat[1] = 0; feat[2] = 0; feat[3] = 0;
        run_sample("sat1", 1'b0);
        run_sample("sat2", 1'b0);
`ifdef PERCEPTRON_UPDATE_SAT_EN
        check_eq("sat_w0_abs", longint'(w_o[0]), 64'sd2147483647);
`else
        check_eq("sat_w0_abs", longint'(w_o[0]), w0_start - 65536);
`endif

        // Reset in the middle of the weight walk
        act = IDENTITY; lr_v = 65536; tgt_v = 65536; pred_v = 0;
        for (int i = 0; i < N; i++) feat[i] = 65536;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state("mid_rst");
        check_eq("mid_rst_ov", longint'(out_valid), 0);
        #3;
        rst_n = 1'b1;
        ovc = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) ovc++;
        end
        check_eq("mid_rst_no_ov", ovc, 0);
        check_eq("mid_rst_rdy", longint'(in_ready), 1);
        feat[0] = 65536; feat[1] = -131072; feat[2] = 196608; feat[3] = 0;
        run_sample("post_rst", 1'b0);

        // Randomized samples
        for (int k = 0; k < 40; k++) begin
            act = act_func'($urandom_range(0, 3));
            for (int i = 0; i < N; i++) feat[i] = rnd_fx(262144);
            sum_v = rnd_fx(131072);
            lr_v  = 32'($urandom_range(0, 65536));
            if (act == HEAVISIDE_STEP) begin
                tgt_v  = 32'($urandom_range(0, 1));
                pred_v = 32'($urandom_range(0, 1));
            end else begin
                tgt_v  = rnd_fx(262144);
                pred_v = ($urandom_range(0, 3) == 0) ? tgt_v
                                                     : rnd_fx(262144);
            end
            run_sample($sformatf("rnd%0d", k), k[2]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
